// File: rtl/brus16_video_pkg.sv
// Shared video constants for the rectangle renderer: default raster timing,
// rectangle table layout, the colour-key value and the fetch FSM states.
package brus16_video_pkg;

   localparam int H_DISPLAY  = 640;
   localparam int H_MAX      = 799;
   localparam int V_MAX      = 524;

   localparam int RECT_WORDS = 5;

   localparam logic [2:0] FLD_X     = 3'd0;
   localparam logic [2:0] FLD_Y     = 3'd1;
   localparam logic [2:0] FLD_W     = 3'd2;
   localparam logic [2:0] FLD_H     = 3'd3;
   localparam logic [2:0] FLD_COLOR = 3'd4;

   localparam logic [15:0] COLOR_KEY = 16'hF81F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/rect_slot.sv
// One active rectangle slot: holds the entry used for the current line and
// reports whether the current pixel column falls inside it.
module rect_slot
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        valid_in,
   input  logic [15:0] x_in,
   input  logic [16:0] end_in,
   input  logic [15:0] color_in,
   input  logic [9:0]  hpos,
   output logic        hit,
   output logic [15:0] color
);

   import brus16_video_pkg::*;

   logic        valid_q;
   logic [15:0] x_q;
   logic [16:0] end_q;
   logic [16:0] hpos_ext;

   // Copy the shadow entry in at the end of each line; reset only drops valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= valid_in;
         x_q     <= x_in;
         end_q   <= end_in;
         color   <= color_in;
      end
   end

   // 17-bit compare so that x + w never wraps back into the visible area.
   always_comb begin
      hpos_ext = {7'd0, hpos};
      hit      = valid_q && (hpos_ext >= {1'b0, x_q}) && (hpos_ext < end_q);
   end

endmodule

// File: rtl/rect_renderer.sv
// Rectangle renderer: fetches the rectangle table during horizontal blanking,
// keeps the entries covering the next line in shadow slots, swaps them into
// the active slots at end of line and outputs a registered RGB565 pixel.
// Optional feature macro: RENDER_COLORKEY_EN (entries coloured 16'hF81F are
// treated as transparent).
//
// state    | meaning
// ST_IDLE  | waiting for hpos == H_DISPLAY to start the table fetch
// ST_ISSUE | issuing one read per cycle across the whole table
// ST_DRAIN | waiting one cycle for the final word to be captured
module rect_renderer
#(
   parameter int          RECT_COUNT = 16,
   parameter logic [15:0] RECT_BASE  = 16'h0000,
   parameter int          H_DISPLAY  = brus16_video_pkg::H_DISPLAY,
   parameter int          H_MAX      = brus16_video_pkg::H_MAX,
   parameter int          V_MAX      = brus16_video_pkg::V_MAX
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  hpos,
   input  logic [9:0]  vpos,
   input  logic        display_on,
   input  logic [15:0] bg_color,
   output logic        mem_rd_en,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   output logic [15:0] rgb
);

   import brus16_video_pkg::*;

   localparam int TOTAL_WORDS = RECT_WORDS * RECT_COUNT;
   localparam int CNT_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
   localparam int IDX_W       = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;

   localparam logic [9:0] HPOS_FETCH = 10'(H_DISPLAY);
   localparam logic [9:0] HPOS_SWAP  = 10'(H_MAX);
   localparam logic [9:0] VPOS_LAST  = 10'(V_MAX);

   fetch_state_t     state;
   logic [CNT_W-1:0] issue_left;
   logic [2:0]       iss_word;
   logic [IDX_W-1:0] iss_entry;
   logic [9:0]       next_line;

   logic             cap_en;
   logic [2:0]       cap_word;
   logic [IDX_W-1:0] cap_entry;

   logic [15:0]      stage_x;
   logic [15:0]      stage_y;
   logic [15:0]      stage_w;
   logic [15:0]      stage_h;

   logic             cap_valid;
   logic [16:0]      cap_end;

   logic             shadow_valid [RECT_COUNT];
   logic [15:0]      shadow_x     [RECT_COUNT];
   logic [16:0]      shadow_end   [RECT_COUNT];
   logic [15:0]      shadow_color [RECT_COUNT];

   logic             swap;
   logic [RECT_COUNT-1:0] slot_hit;
   logic [15:0]      slot_color [RECT_COUNT];

   logic             any_hit;
   logic [15:0]      win_color;

   // Fetch sequencer: issue_left counts down to terminal count zero on the last read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         mem_rd_en  <= 1'b0;
         mem_addr   <= 16'h0000;
         issue_left <= '0;
         iss_word   <= 3'd0;
         iss_entry  <= '0;
         next_line  <= 10'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hpos == HPOS_FETCH) begin
                  state      <= ST_ISSUE;
                  mem_rd_en  <= 1'b1;
                  mem_addr   <= RECT_BASE;
                  issue_left <= CNT_W'(TOTAL_WORDS - 1);
                  iss_word   <= FLD_X;
                  iss_entry  <= '0;
                  next_line  <= (vpos == VPOS_LAST) ? 10'd0 : vpos + 10'd1;
               end
            end
            ST_ISSUE: begin
               if (issue_left == '0) begin
                  state     <= ST_DRAIN;
                  mem_rd_en <= 1'b0;
               end else begin
                  mem_addr   <= mem_addr + 16'd1;
                  issue_left <= issue_left - CNT_W'(1);
                  if (iss_word == FLD_COLOR) begin
                     iss_word  <= FLD_X;
                     iss_entry <= iss_entry + IDX_W'(1);
                  end else begin
                     iss_word <= iss_word + 3'd1;
                  end
               end
            end
            ST_DRAIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state     <= ST_IDLE;
               mem_rd_en <= 1'b0;
            end
         endcase
      end
   end

   // Read data lags the strobe by one cycle, so the word tag travels with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_en    <= 1'b0;
         cap_word  <= 3'd0;
         cap_entry <= '0;
      end else begin
         cap_en    <= mem_rd_en;
         cap_word  <= iss_word;
         cap_entry <= iss_entry;
      end
   end

   // Coverage test for the entry whose colour word is arriving now.
   always_comb begin
      logic [16:0] y_top;
      logic [16:0] y_bot;
      logic [16:0] line_ext;
      y_top     = {1'b0, stage_y};
      y_bot     = {1'b0, stage_y} + {1'b0, stage_h};
      line_ext  = {7'd0, next_line};
      cap_end   = {1'b0, stage_x} + {1'b0, stage_w};
      cap_valid = (stage_w != 16'd0) && (stage_h != 16'd0) &&
                  (y_top <= line_ext) && (line_ext < y_bot);
`ifdef RENDER_COLORKEY_EN
      if (mem_data == COLOR_KEY) begin
         cap_valid = 1'b0;
      end
`endif
   end

   // Staging of x/y/w/h, and shadow slot write when the colour word lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RECT_COUNT; i++) begin
            shadow_valid[i] <= 1'b0;
         end
      end else if (cap_en) begin
         case (cap_word)
            FLD_X: stage_x <= mem_data;
            FLD_Y: stage_y <= mem_data;
            FLD_W: stage_w <= mem_data;
            FLD_H: stage_h <= mem_data;
            FLD_COLOR: begin
               shadow_valid[cap_entry] <= cap_valid;
               shadow_x[cap_entry]     <= stage_x;
               shadow_end[cap_entry]   <= cap_end;
               shadow_color[cap_entry] <= mem_data;
            end
            default: ;
         endcase
      end
   end

   assign swap = (hpos == HPOS_SWAP);

   for (genvar g = 0; g < RECT_COUNT; g++) begin : g_slot
      rect_slot u_slot (
         .clk      (clk),
         .reset    (reset),
         .load     (swap),
         .valid_in (shadow_valid[g]),
         .x_in     (shadow_x[g]),
         .end_in   (shadow_end[g]),
         .color_in (shadow_color[g]),
         .hpos     (hpos),
         .hit      (slot_hit[g]),
         .color    (slot_color[g])
      );
   end

   // Priority mux: scanning upward lets the highest-index hit win.
   always_comb begin
      any_hit   = 1'b0;
      win_color = 16'h0000;
      for (int i = 0; i < RECT_COUNT; i++) begin
         if (slot_hit[i]) begin
            any_hit   = 1'b1;
            win_color = slot_color[i];
         end
      end
   end

   // Registered pixel output; black outside the visible area.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb <= 16'h0000;
      end else if (display_on) begin
         rgb <= any_hit ? win_color : bg_color;
      end else begin
         rgb <= 16'h0000;
      end
   end

endmodule

// File: tb/tb_rect_renderer.sv
// Directed bench for rect_renderer: drives hpos/vpos line by line (skipping
// lines that are not of interest), models a one-cycle-latency video memory
// and checks pixels and fetch strobes against hand-computed values.
module tb_rect_renderer;

   localparam logic [15:0] BG   = 16'h001F;
   localparam logic [15:0] BASE = 16'h0000;

   logic        clk;
   logic        reset;
   logic [9:0]  hpos;
   logic [9:0]  vpos;
   logic        display_on;
   logic [15:0] bg_color;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic [15:0] rgb;

   logic [15:0] mem [0:127];

   int total;
   int bad;

   rect_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .hpos       (hpos),
      .vpos       (vpos),
      .display_on (display_on),
      .bg_color   (bg_color),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .rgb        (rgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_data <= mem[mem_addr[6:0]];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int v, input int h);
      vpos       = 10'(v);
      hpos       = 10'(h);
      display_on = (h < 640) && (v < 480);
      @(posedge clk);
      #1;
   endtask

   task automatic run_span(input int v, input int h_from, input int h_to);
      for (int h = h_from; h <= h_to; h++) step(v, h);
   endtask

   task automatic run_line(input int v, input string tag,
                           input int h0, input logic [15:0] e0,
                           input int h1, input logic [15:0] e1,
                           input int h2, input logic [15:0] e2,
                           input int h3, input logic [15:0] e3);
      for (int h = 0; h < 800; h++) begin
         step(v, h);
         if (h == h0) chk({tag, "_a"}, rgb, e0);
         if (h == h1) chk({tag, "_b"}, rgb, e1);
         if (h == h2) chk({tag, "_c"}, rgb, e2);
         if (h == h3) chk({tag, "_d"}, rgb, e3);
      end
   endtask

   task automatic set_entry(input int i, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] w, input logic [15:0] h, input logic [15:0] c);
      mem[5*i+0] = x;
      mem[5*i+1] = y;
      mem[5*i+2] = w;
      mem[5*i+3] = h;
      mem[5*i+4] = c;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      bg_color   = BG;
      hpos       = 10'd0;
      vpos       = 10'd0;
      display_on = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;

      // reset with visible pixels: output held black, memory idle
      run_span(0, 0, 9);
      chk("reset_rgb", rgb, 16'h0000);
      chk("reset_rd_en", {15'd0, mem_rd_en}, 16'd0);
      chk("reset_addr", mem_addr, 16'h0000);
      reset = 1'b0;
      step(0, 10);
      chk("prefetch_bg", rgb, BG);
      run_span(0, 11, 799);

      // empty table: background in the visible area, black in blanking
      run_line(1, "empty", 50, BG, 700, 16'h0000, -1, 0, -1, 0);

      // fetch timing, outputs registered one cycle after the hpos sample
      for (int h = 0; h < 800; h++) begin
         step(5, h);
         if (h == 640) begin
            chk("fetch_rise_en", {15'd0, mem_rd_en}, 16'd1);
            chk("fetch_first_addr", mem_addr, BASE);
         end
         if (h == 719) begin
            chk("fetch_last_en", {15'd0, mem_rd_en}, 16'd1);
            chk("fetch_last_addr", mem_addr, BASE + 16'd79);
         end
         if (h == 720) chk("fetch_fall_en", {15'd0, mem_rd_en}, 16'd0);
      end

      // single rectangle: x 10..14, lines 20..21
      set_entry(0, 16'd10, 16'd20, 16'd5, 16'd2, 16'hF800);
      run_line(19, "single_pre", -1, 0, -1, 0, -1, 0, -1, 0);
      run_line(20, "single_l20", 9, BG, 10, 16'hF800, 14, 16'hF800, 15, BG);
      run_line(21, "single_l21", 10, 16'hF800, 14, 16'hF800, -1, 0, -1, 0);
      run_line(22, "single_l22", 12, BG, -1, 0, -1, 0, -1, 0);

      // overlap: entry 3 spans 100..119, entry 7 spans 105..114, lines 40..42
      set_entry(3, 16'd100, 16'd40, 16'd20, 16'd3, 16'h07E0);
      set_entry(7, 16'd105, 16'd40, 16'd10, 16'd3, 16'hFFFF);
      run_line(39, "overlap_pre", -1, 0, -1, 0, -1, 0, -1, 0);
      mem[5*7+2] = 16'd0;
      run_line(40, "overlap_l40", 102, 16'h07E0, 107, 16'hFFFF, 115, 16'h07E0, 120, BG);
      run_line(41, "overlap_w0", 107, 16'h07E0, -1, 0, -1, 0, -1, 0);

      // entry 2 would cover line 62 unless the fetch during line 61 is lost
      set_entry(2, 16'd200, 16'd62, 16'd10, 16'd1, 16'hAAAA);
      run_line(59, "midline_pre", -1, 0, -1, 0, -1, 0, -1, 0);
      run_span(60, 0, 299);
      mem[0] = 16'd400;
      mem[1] = 16'd60;
      for (int h = 300; h < 800; h++) begin
         step(60, h);
         if (h == 402) chk("midline_same_line", rgb, BG);
      end
      for (int h = 0; h < 800; h++) begin
         if (h == 660) reset = 1'b1;
         step(61, h);
         reset = 1'b0;
         if (h == 12) chk("midline_old_gone", rgb, BG);
         if (h == 402) chk("midline_new_on", rgb, 16'hF800);
         if (h == 659) chk("midfetch_en_before", {15'd0, mem_rd_en}, 16'd1);
         if (h == 660) chk("midfetch_en_drop", {15'd0, mem_rd_en}, 16'd0);
      end
      run_line(62, "midfetch_l62", 205, BG, -1, 0, -1, 0, -1, 0);

      // frame wrap: fetch on line 524 feeds line 0
      set_entry(4, 16'd300, 16'd0, 16'd4, 16'd1, 16'h1234);
      run_line(524, "wrap_pre", -1, 0, -1, 0, -1, 0, -1, 0);
      run_line(0, "wrap_l0", 299, BG, 300, 16'h1234, 303, 16'h1234, 304, BG);

      // colour key: entry 1 magenta over entry 0 red
      set_entry(0, 16'd500, 16'd70, 16'd10, 16'd1, 16'hF800);
      set_entry(1, 16'd500, 16'd70, 16'd10, 16'd1, 16'hF81F);
      run_line(69, "ckey_pre", -1, 0, -1, 0, -1, 0, -1, 0);
`ifdef RENDER_COLORKEY_EN
      run_line(70, "ckey", 505, 16'hF800, 510, BG, -1, 0, -1, 0);
`else
      run_line(70, "ckey", 505, 16'hF81F, 510, BG, -1, 0, -1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rect_renderer.md
# rect_renderer

Pixel-generation stage directly downstream of the VGA sync generator. It consumes `hpos`/`vpos`/`display_on` and produces the 16-bit RGB565 pixel for every clock. During each line's horizontal blanking it reads a rectangle table from video memory and latches the rectangles covering the next line. During the visible interval it outputs the colour of the highest-priority covering rectangle, or the background colour.

## Interface
Parameters:
- `RECT_COUNT`, 16: number of table entries; `RECT_COUNT*5 + 2` must not exceed `H_TOTAL - H_DISPLAY`.
- `RECT_BASE`, 16'h0000: word address of entry 0.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_MAX`, 799: last `hpos` of a line.
- `V_MAX`, 524: last `vpos` of a frame.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `hpos`, in, 10: current pixel column from the sync generator.
- `vpos`, in, 10: current line from the sync generator.
- `display_on`, in, 1: visible-area flag.
- `bg_color`, in, 16: background RGB565 colour, sampled per pixel.
- `mem_rd_en`, out, 1: video memory read strobe.
- `mem_addr`, out, 16: video memory word address.
- `mem_data`, in, 16: read data, valid exactly 1 cycle after `mem_rd_en`.
- `rgb`, out, 16: registered pixel colour.

## Operation
Table layout:
- Entry i occupies `RECT_BASE + 5*i` onward.
- Words, in order: x, y, w, h, color. All unsigned 16-bit.

Fetch FSM, states IDLE, ISSUE, DRAIN:
- IDLE→ISSUE when `hpos == H_DISPLAY`. Latch `next_line = (vpos == V_MAX) ? 0 : vpos + 1`.
- ISSUE: assert `mem_rd_en` for exactly `5*RECT_COUNT` consecutive cycles. `mem_addr` runs from `RECT_BASE` to `RECT_BASE + 5*RECT_COUNT - 1`, incrementing by 1.
- ISSUE→DRAIN after the last address. DRAIN→IDLE after one cycle, when the last word is captured.

Capture and shadow slot update:
- Captured words are written into a per-entry staging area.
- On capture of word 4 (color), shadow slot i is set to: `valid = (w != 0) && (h != 0) && (y <= next_line) && (next_line < y + h)`, plus x, end = x + w, and color.
- y+h and x+w use 17-bit arithmetic, so there is no wrap-around.

Slot swap:
- At `hpos == H_MAX`, all shadow slots copy to the active slots in one cycle.
- Table writes made during a line therefore take effect no earlier than the next line.

Per-pixel selection:
- `hit_i = active_valid_i && hpos >= x_i && hpos < end_i`, with `hpos` zero-extended to 17 bits.
- Highest index i with `hit_i` wins.
- `rgb <= display_on ? (any hit ? color_win : bg_color) : 16'h0000`.

Reset, including mid-fetch:
- FSM goes to IDLE; all shadow and active valid bits clear.
- `mem_rd_en = 0`, `mem_addr = 0`, `rgb = 0`.
- Until the first complete fetch and swap, visible pixels show `bg_color`.

Boundary behaviour:
- A rectangle with x ≥ 640 never hits.
- A rectangle with end > 640 is clipped by `display_on`.
- A fetch always completes within one line's blanking.

## Timing
- `rgb` lags `hpos` by 1 cycle. This matches the sync generator's registered `hsync`/`vsync`, so syncs need no extra delay.
- Read latency is fixed at 1 cycle. No back-pressure; memory must respond every cycle.
- With the default parameters:
  - ISSUE covers `hpos` 640–719.
  - The last capture occurs at `hpos` 720.
  - The swap occurs at `hpos` 799.
  - Active slots are therefore valid for the whole next line.

## Configuration
- `RENDER_COLORKEY_EN` defined: an entry whose color equals 16'hF81F gets shadow valid = 0 and is transparent (lower-priority rectangles show through).
- `RENDER_COLORKEY_EN` undefined: 16'hF81F is drawn as ordinary magenta.

## Structure
- Package `brus16_video_pkg` holds:
  - timing constants (`H_DISPLAY`, `H_MAX`, `V_MAX`);
  - `RECT_WORDS = 5`;
  - field offsets (X, Y, W, H, COLOR);
  - the colour-key constant;
  - the fetch FSM state enum.
- Sub-module `rect_slot`: one active entry with its x/end/color/valid registers and the 17-bit hit comparator. Instantiated `RECT_COUNT` times.
- The top level holds the FSM, the staging logic, and the priority mux.

## Test plan
1. **Reset and empty table.** Assert reset, then release with all table words 0 and `bg_color = 16'h001F`. Required: `rgb = 0` during reset. After the first swap, `rgb = 16'h001F` in the visible area and 0 in blanking.
2. **Single rectangle.** Entry 0 = {x=10, y=20, w=5, h=2, color=16'hF800}. Required:
   - lines 20–21, pixels 10–14: `rgb = 16'hF800`;
   - pixels 9 and 15: `bg_color`;
   - line 22: all `bg_color`.
3. **Overlap priority.** Entries 3 (16'h07E0) and 7 (16'hFFFF) cover the same area. Required: `rgb = 16'hFFFF` there; with entry 7 given w=0, `rgb = 16'h07E0`.
4. **Fetch timing.** At `vpos = 5`:
   - `mem_rd_en` rises at `hpos = 640` with `mem_addr = RECT_BASE`;
   - last address `RECT_BASE + 79` at `hpos = 719`;
   - `mem_rd_en` low from 720;
   - at `vpos = 524`, the fetched data is used for line 0.
5. **Mid-line change and mid-fetch reset.**
   - Change entry 0's y at `hpos = 300`: the current line is unchanged, and the change applies from the following fetch.
   - Pulse reset at `hpos = 660`: `mem_rd_en` drops the next cycle, and the next line renders `bg_color` only.
6. **Colour key.** Entry 1 = 16'hF81F over entry 0 = 16'hF800. Required: with `RENDER_COLORKEY_EN`, `rgb = 16'hF800`; without it, `rgb = 16'hF81F`.
